// File: rtl/sample_mem_responder.sv
// sample_mem_responder: single-port memory responder with strobe handshake, read latency and periodic refresh
module sample_mem_responder #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int MEM_LAT = 2,
  parameter int WAIT_CYC = 2,
  parameter int REFRESH_PERIOD = 390,
  parameter int REFRESH_CYC = 8
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              read_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int MAX_A = MEM_LAT > WAIT_CYC ? MEM_LAT : WAIT_CYC;
  localparam int MAX_B = REFRESH_CYC > REFRESH_PERIOD ? REFRESH_CYC : REFRESH_PERIOD;
  localparam int MAX_V = MAX_A > MAX_B ? MAX_A : MAX_B;
  localparam int CW = $clog2(MAX_V + 1);
  localparam logic [CW-1:0] LAT_END = CW'(MEM_LAT);
  localparam logic [CW-1:0] WR_END = CW'(WAIT_CYC);
  localparam logic [CW-1:0] RF_END = CW'(REFRESH_CYC - 1);
  localparam logic [CW-1:0] RP_END = CW'(REFRESH_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, WR_WAIT, RD_WAIT, HOLD, REFRESH} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, rcnt;
  logic ref_pend, accept_w, accept_r, ref_go, capture;

  // state register with per-state cycle counter
  always_ff @(posedge clk50 or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end

  // next state: write beats read beats refresh in IDLE; counter restarts on every state change
  always_comb begin
    state_nxt = accept_w ? WR_WAIT :
                accept_r ? RD_WAIT :
                ref_go ? REFRESH :
                (state == WR_WAIT && cnt == WR_END) || capture ? HOLD :
                (state == HOLD && !read && !write) || (state == REFRESH && cnt == RF_END) ? IDLE :
                state;
    cnt_nxt = state_nxt != state ? '0 : cnt + 1'b1;
  end

  // outputs and decode, strobes fire in the first cycle of their wait state
  always_comb begin
    busy = state != IDLE;
    mem_we = state == WR_WAIT && cnt == '0;
    mem_re = state == RD_WAIT && cnt == '0;
    accept_w = state == IDLE && write;
    accept_r = state == IDLE && !write && read;
    ref_go = state == IDLE && !write && !read && ref_pend;
    capture = state == RD_WAIT && cnt == LAT_END;
  end

  // request latching and read data capture
  always_ff @(posedge clk50 or negedge rst) begin
    if (!rst) begin
      mem_addr <= '0;
      mem_wdata <= '0;
      rdata <= '0;
      read_ready <= 1'b0;
    end else begin
      mem_addr <= accept_w ? waddr : accept_r ? raddr : mem_addr;
      mem_wdata <= accept_w ? wdata : mem_wdata;
      rdata <= capture ? mem_rdata : rdata;
      read_ready <= capture;
    end
  end

  // free-running refresh timer; a wrap is remembered in one sticky bit
  always_ff @(posedge clk50 or negedge rst) begin
    if (!rst) begin
      rcnt <= '0;
      ref_pend <= 1'b0;
    end else begin
      rcnt <= rcnt == RP_END ? '0 : rcnt + 1'b1;
      ref_pend <= (rcnt == RP_END) | (ref_pend & !ref_go);
    end
  end
endmodule

// File: tb/tb_sample_mem_responder.sv
// tb_sample_mem_responder: vector table, corner sequences and random traffic against a transaction-level model
module tb_sample_mem_responder;
  localparam int AW = 24, DW = 16, ML = 2, WC = 2, RP = 390, RC = 8;

  logic clk50 = 0, rst = 0, read = 0, write = 0;
  logic [AW-1:0] raddr = '0, waddr = '0;
  logic [DW-1:0] wdata = '0, mem_rdata = '0;
  logic busy, read_ready, mem_we, mem_re;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  sample_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(ML), .WAIT_CYC(WC),
    .REFRESH_PERIOD(RP), .REFRESH_CYC(RC)) dut (
    .clk50(clk50), .rst(rst), .read(read), .write(write), .raddr(raddr), .waddr(waddr),
    .wdata(wdata), .busy(busy), .rdata(rdata), .read_ready(read_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata));

  always #10 clk50 = ~clk50;

  bit [DW-1:0] bmem [bit [AW-1:0]];
  bit [DW-1:0] ref_mem [bit [AW-1:0]];
  logic [AW-1:0] b_addr = '0, we_a, re_a;
  logic [DW-1:0] we_d, rr_d;
  int b_age = 100, cyc = 0, edges = 0;
  int we_n = 0, re_n = 0, rr_n = 0, re_cyc = 0, rr_cyc = 0;
  int chk = 0, pass_n = 0;

  function automatic bit [DW-1:0] bget(input bit [AW-1:0] a);
    return bmem.exists(a) ? bmem[a] : '0;
  endfunction

  function automatic bit [DW-1:0] rget(input bit [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic int mx(input int a, input int b);
    return a > b ? a : b;
  endfunction

  always @(posedge clk50) begin
    cyc++;
    edges = rst ? edges + 1 : 0;
  end

  // backend memory: data valid only in the cycle MEM_LAT after mem_re, inverted otherwise
  always @(negedge clk50) begin
    if (mem_we) begin
      we_n++;
      we_a = mem_addr;
      we_d = mem_wdata;
      bmem[mem_addr] = mem_wdata;
    end
    if (mem_re) begin
      re_n++;
      re_a = mem_addr;
      re_cyc = cyc;
      b_addr = mem_addr;
      b_age = 0;
    end else if (b_age < 100) b_age++;
    if (read_ready) begin
      rr_n++;
      rr_d = rdata;
      rr_cyc = cyc;
    end
    mem_rdata = b_age == ML ? bget(b_addr) : ~bget(b_addr);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk50);
    #1;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick;
      n++;
    end
    if (busy) check("idle_timeout", busy, 0);
  endtask

  task automatic txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int e,
                     input int exp_busy, input logic [DW-1:0] exp_rd, input string nm);
    int w0, r0, q0, n;
    wait_idle;
    w0 = we_n; r0 = re_n; q0 = rr_n;
    if (wr) begin
      write = 1; waddr = a; wdata = d;
    end else begin
      read = 1; raddr = a;
    end
    tick;
    check({nm, " busy_rise"}, busy, 1);
    n = 0;
    while (busy && n < 2000) begin
      if (n == e) begin
        write = 0;
        read = 0;
      end
      n++;
      tick;
    end
    write = 0;
    read = 0;
    check({nm, " busy_len"}, n, exp_busy);
    if (wr) begin
      check({nm, " we_count"}, we_n - w0, 1);
      check({nm, " we_addr"}, we_a, a);
      check({nm, " we_data"}, we_d, d);
      check({nm, " no_re"}, re_n - r0, 0);
      ref_mem[a] = d;
    end else begin
      check({nm, " re_count"}, re_n - r0, 1);
      check({nm, " re_addr"}, re_a, a);
      check({nm, " ready_count"}, rr_n - q0, 1);
      check({nm, " ready_data"}, rr_d, exp_rd);
      check({nm, " rdata_hold"}, rdata, exp_rd);
      check({nm, " ready_delay"}, rr_cyc - re_cyc, ML + 1);
      check({nm, " no_we"}, we_n - w0, 0);
    end
  endtask

  typedef struct {
    bit wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int e;
    int exp_busy;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t tbl[8];
  logic [AW-1:0] pool[6];

  initial begin
    int w0, r0, q0, n, m, hi;
    bit wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    tbl[0] = '{1'b1, 24'h00000A, 16'h1234, 0, WC + 2, 16'h0000};
    tbl[1] = '{1'b0, 24'h00000A, 16'h0000, 0, ML + 2, 16'h1234};
    tbl[2] = '{1'b1, 24'hFFFFFF, 16'hFFFF, 1, WC + 2, 16'h0000};
    tbl[3] = '{1'b0, 24'hFFFFFF, 16'h0000, 3, ML + 2, 16'hFFFF};
    tbl[4] = '{1'b1, 24'h800001, 16'hA5C3, 20, 21, 16'h0000};
    tbl[5] = '{1'b0, 24'h800001, 16'h0000, 7, 8, 16'hA5C3};
    tbl[6] = '{1'b0, 24'h00000A, 16'h0000, 0, ML + 2, 16'h1234};
    tbl[7] = '{1'b0, 24'h123456, 16'h0000, 0, ML + 2, 16'h0000};
    pool = '{24'h000000, 24'hFFFFFF, 24'h00000A, 24'hABCDEF, 24'h000005, 24'h000009};

    write = 1; waddr = 24'h000033; wdata = 16'h7777;
    repeat (3) tick;
    check("rst busy", busy, 0);
    check("rst read_ready", read_ready, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_re", mem_re, 0);
    check("rst rdata", rdata, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst no_we", we_n, 0);
    write = 0;
    rst = 1;
    tick;

    for (int i = 0; i < 8; i++)
      txn(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].e, tbl[i].exp_busy, tbl[i].exp_rd, $sformatf("vec%0d", i));

    wait_idle;
    w0 = we_n; r0 = re_n;
    write = 1; waddr = 24'h000005; wdata = 16'h5A5A;
    read = 1; raddr = 24'h000009;
    tick;
    check("rw busy_rise", busy, 1);
    write = 0;
    repeat (5) tick;
    check("rw we_count", we_n - w0, 1);
    check("rw we_addr", we_a, 24'h000005);
    check("rw no_early_re", re_n - r0, 0);
    read = 0;
    wait_idle;
    check("rw no_re_in_txn", re_n - r0, 0);
    ref_mem[24'h000005] = 16'h5A5A;
    txn(0, 24'h000009, '0, 0, ML + 2, rget(24'h000009), "rw read9");
    txn(0, 24'h000005, '0, 0, ML + 2, 16'h5A5A, "rw read5");

    txn(0, 24'h00000A, '0, 0, ML + 2, 16'h1234, "pre_rst read");
    wait_idle;
    r0 = re_n; q0 = rr_n;
    read = 1; raddr = 24'h00000A;
    tick;
    check("mid_rst busy_rise", busy, 1);
    read = 0;
    tick;
    #3 rst = 0;
    #1;
    check("mid_rst busy", busy, 0);
    check("mid_rst rdata", rdata, 0);
    check("mid_rst read_ready", read_ready, 0);
    check("mid_rst mem_re", mem_re, 0);
    repeat (4) tick;
    check("mid_rst no_ready", rr_n - q0, 0);
    check("mid_rst one_re", re_n - r0, 1);
    rst = 1;
    tick;
    txn(0, 24'h00000A, '0, 0, ML + 2, 16'h1234, "post_rst read");

    txn(1, 24'h000077, 16'h4242, 900, 901, '0, "ref_hold write");
    w0 = we_n; r0 = re_n;
    tick;
    check("ref start", busy, 1);
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick;
    end
    check("ref length", n, RC);
    check("ref no_strobe", (we_n - w0) + (re_n - r0), 0);
    m = RP - (edges % RP);
    if (m > 30) m = 30;
    hi = 0;
    repeat (m) begin
      tick;
      if (busy) hi++;
    end
    check("ref single", hi, 0);

    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      a = pool[$urandom_range(0, 5)];
      d = 16'($urandom);
      n = $urandom_range(0, 6);
      txn(wr, a, d, n, mx(wr ? WC + 2 : ML + 2, n + 1), rget(a), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_n, chk);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
